task4: RTL and testbench
========================

TASK4 -- requirements
Module: task4

Interface
REQ-001 The block SHALL have one clock, KEY[0], with the reset synchronous and active-low on KEY[3]; no other signal shall clock any register.
REQ-002 Port KEY[0]  input  1  slow game clock; every register updates on its rising edge.
REQ-003 Port KEY[3]  input  1  reset_n, synchronous active-low, sampled on rising KEY[0].
REQ-004 Port KEY[2:1]  input  2  unused and ignored.
REQ-005 Port CLOCK_50  input  1  present for board compatibility; unused and drives no logic.
REQ-006 Port LEDR  output  10  [3:0] player score, [7:4] dealer score, [9:8] driven 0.
REQ-007 Port HEX0/HEX1/HEX2  output  7 each  player cards 1/2/3, active-low 7-segment, bit order gfedcba.
REQ-008 Port HEX3/HEX4/HEX5  output  7 each  dealer cards 1/2/3, same encoding.

Function
REQ-009 Cards SHALL be 4-bit values: 0 = no card, 1 = ace, 2..10 = pips, 11 = J, 12 = Q, 13 = K; 14 and 15 are invalid.
REQ-010 The card source SHALL be a 4-bit register new_card that advances 1,2,..,13,1,.. on every rising KEY[0] and loads 1 on reset.
REQ-011 The FSM SHALL have states DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2 and DONE, and reset SHALL put it in DEAL_P1.
REQ-012 On each rising KEY[0] with reset_n=1 and the FSM in a DEAL state, the block SHALL load new_card into that state's card register: pcard1, dcard1, pcard2 or dcard2.
REQ-013 After each such load the FSM SHALL advance DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2->DONE.
REQ-014 DONE SHALL be absorbing: no card register changes there, and only reset leaves it.
REQ-015 pcard3 and dcard3 SHALL exist but stay 0 in this block, so HEX2 and HEX5 show blank.
REQ-016 The value of a card SHALL be the card itself for 1..9 and 0 for 0 and 10..15.
REQ-017 Each score SHALL be the sum of its three card values modulo 10, as a combinational 4-bit result (0..9).
REQ-018 The HEX encoding SHALL be: 0 -> 1111111, 1 -> 0001000, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000.
REQ-019 The HEX encoding SHALL continue: 10 -> 1000000, 11 -> 1100001, 12 -> 0011000, 13 -> 0001001, 14 and 15 -> 1111111.
REQ-020 All HEX and LEDR outputs SHALL be combinational from the card registers, so a new card shows right after the edge that loaded it (0 cycles of extra latency).

Reset
REQ-021 On a rising KEY[0] with KEY[3]=0, all six card registers SHALL clear to 0, the FSM SHALL go to DEAL_P1 and new_card SHALL load 1.
REQ-022 After reset all HEX outputs SHALL be 1111111 and LEDR SHALL be 0.
REQ-023 Reset SHALL take priority over dealing, including when it is asserted mid-deal or in DONE.
REQ-024 Reset SHALL take no effect without a KEY[0] edge.

Structure
REQ-025 The card/state encodings and the HEX pattern constants SHALL live in a shared package.
REQ-026 The top level SHALL instantiate a datapath as instance dp and a state-machine module.
REQ-027 dp SHALL contain a sub-module dealcard, instance DEL, whose output port is named new_card, so benches can force dp.DEL.new_card.
REQ-028 dp SHALL also hold the card registers, card7seg decoders and scorehand adders.

Verification
REQ-029 Reset (KEY[3]=0 plus a KEY[0] pulse) -> all HEX 1111111, LEDR[7:0]=0.
REQ-030 With new_card forced to 3, 1, 12, 9 over four pulses -> HEX0=3 / LEDR[3:0]=3, then HEX3=ace / LEDR[7:4]=1, then HEX1=queen with player score still 3, then HEX4=9 with dealer score 0.
REQ-031 A fifth pulse after scenario REQ-030 -> all outputs unchanged (DONE holds).
REQ-032 Reset then forced 13, 4, 7, 11 -> HEX0=king with player 0, HEX3=4 with dealer 4, HEX1=7 with player 7, HEX4=jack with dealer 4; HEX2 and HEX5 blank throughout.
REQ-033 Reset asserted in DEAL_P2 -> all cards clear and the next pulse loads pcard1 again.
REQ-034 Unforced new_card -> the card sequence advances 1..13 and wraps to 1; each card10 value displays as 1000000 and adds 0 to the score.

Source files
------------

// File: rtl/task4_pkg.sv
// Shared card, state and 7-segment definitions for the task4 card dealer.
package task4_pkg;

  localparam int unsigned CARD_W  = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned SCORE_W = 4;

  typedef logic [CARD_W-1:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_NINE = 4'd9;
  localparam card_t CARD_KING = 4'd13;

  typedef enum logic [2:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    DONE
  } state_e;

  // One load strobe per dealt card register.
  typedef struct packed {
    logic pcard1;
    logic dcard1;
    logic pcard2;
    logic dcard2;
  } load_t;

  // Active-low segments, bit order gfedcba.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ACE   = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_10    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_J     = 7'b1100001;
  localparam logic [SEG_W-1:0] SEG_Q     = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_K     = 7'b0001001;

  // Pip cards count at face value; no card, tens and faces count zero.
  function automatic card_t card_value(input card_t c);
    return ((c >= CARD_ACE) && (c <= CARD_NINE)) ? c : CARD_NONE;
  endfunction

endpackage

// File: rtl/card7seg.sv
// Card code to active-low 7-segment pattern.
module card7seg
  import task4_pkg::*;
(
  input  card_t              card,
  output logic [SEG_W-1:0]   hex_c
);

  always_comb begin
    hex_c = SEG_BLANK;
    case (card)
      4'd1:    hex_c = SEG_ACE;
      4'd2:    hex_c = SEG_2;
      4'd3:    hex_c = SEG_3;
      4'd4:    hex_c = SEG_4;
      4'd5:    hex_c = SEG_5;
      4'd6:    hex_c = SEG_6;
      4'd7:    hex_c = SEG_7;
      4'd8:    hex_c = SEG_8;
      4'd9:    hex_c = SEG_9;
      4'd10:   hex_c = SEG_10;
      4'd11:   hex_c = SEG_J;
      4'd12:   hex_c = SEG_Q;
      4'd13:   hex_c = SEG_K;
      default: hex_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dealcard.sv
// Card source: cycles ace..king on every clock, restarting at ace on reset.
module dealcard
  import task4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output card_t new_card
);

  card_t new_card_q, new_card_d;

  always_comb begin
    new_card_d = (new_card_q == CARD_KING) ? CARD_ACE : card_t'(new_card_q + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) new_card_q <= CARD_ACE;
    else        new_card_q <= new_card_d;
  end

  assign new_card = new_card_q;

endmodule

// File: rtl/scorehand.sv
// Hand score: sum of three card values modulo 10.
module scorehand
  import task4_pkg::*;
(
  input  card_t               card1,
  input  card_t               card2,
  input  card_t               card3,
  output logic [SCORE_W-1:0]  score_c
);

  logic [4:0] sum_c;

  always_comb begin
    sum_c   = 5'(card_value(card1)) + 5'(card_value(card2)) + 5'(card_value(card3));
    score_c = SCORE_W'(sum_c % 5'd10);
  end

endmodule

// File: rtl/task4_datapath.sv
// Card source, six card registers, display decoders and score adders.
module task4_datapath
  import task4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  load_t             load_c,
  output logic [SEG_W-1:0]  hex0_c,
  output logic [SEG_W-1:0]  hex1_c,
  output logic [SEG_W-1:0]  hex2_c,
  output logic [SEG_W-1:0]  hex3_c,
  output logic [SEG_W-1:0]  hex4_c,
  output logic [SEG_W-1:0]  hex5_c,
  output logic [9:0]        ledr_c
);

  card_t new_card;
  card_t pcard1_q, pcard2_q, pcard3_q, dcard1_q, dcard2_q, dcard3_q;
  card_t pcard1_d, pcard2_d, pcard3_d, dcard1_d, dcard2_d, dcard3_d;
  logic [SCORE_W-1:0] pscore_c, dscore_c;

  dealcard DEL (.clk(clk), .rst_n(rst_n), .new_card(new_card));

  // Third cards are reserved for a later drawing stage and stay empty here.
  always_comb begin
    pcard1_d = load_c.pcard1 ? new_card : pcard1_q;
    dcard1_d = load_c.dcard1 ? new_card : dcard1_q;
    pcard2_d = load_c.pcard2 ? new_card : pcard2_q;
    dcard2_d = load_c.dcard2 ? new_card : dcard2_q;
    pcard3_d = CARD_NONE;
    dcard3_d = CARD_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcard1_q <= CARD_NONE;
      pcard2_q <= CARD_NONE;
      pcard3_q <= CARD_NONE;
      dcard1_q <= CARD_NONE;
      dcard2_q <= CARD_NONE;
      dcard3_q <= CARD_NONE;
    end else begin
      pcard1_q <= pcard1_d;
      pcard2_q <= pcard2_d;
      pcard3_q <= pcard3_d;
      dcard1_q <= dcard1_d;
      dcard2_q <= dcard2_d;
      dcard3_q <= dcard3_d;
    end
  end

  card7seg u_seg0 (.card(pcard1_q), .hex_c(hex0_c));
  card7seg u_seg1 (.card(pcard2_q), .hex_c(hex1_c));
  card7seg u_seg2 (.card(pcard3_q), .hex_c(hex2_c));
  card7seg u_seg3 (.card(dcard1_q), .hex_c(hex3_c));
  card7seg u_seg4 (.card(dcard2_q), .hex_c(hex4_c));
  card7seg u_seg5 (.card(dcard3_q), .hex_c(hex5_c));

  scorehand u_pscore (.card1(pcard1_q), .card2(pcard2_q), .card3(pcard3_q), .score_c(pscore_c));
  scorehand u_dscore (.card1(dcard1_q), .card2(dcard2_q), .card3(dcard3_q), .score_c(dscore_c));

  assign ledr_c = {2'b00, dscore_c, pscore_c};

endmodule

// File: rtl/task4_fsm.sv
// Deal sequencer: strobes one card register per clock, then parks in DONE.
module task4_fsm
  import task4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output load_t load_c
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DEAL_P1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_c  = '0;
    case (state_q)
      DEAL_P1: begin load_c.pcard1 = 1'b1; state_d = DEAL_D1; end
      DEAL_D1: begin load_c.dcard1 = 1'b1; state_d = DEAL_P2; end
      DEAL_P2: begin load_c.pcard2 = 1'b1; state_d = DEAL_D2; end
      DEAL_D2: begin load_c.dcard2 = 1'b1; state_d = DONE;    end
      DONE:    state_d = DONE;
      default: state_d = DEAL_P1;
    endcase
  end

endmodule

// File: rtl/task4.sv
// Board top: KEY[0] is the game clock, KEY[3] the synchronous active-low reset.
module task4
  import task4_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic [3:0]       KEY,
  output logic [9:0]       LEDR,
  output logic [SEG_W-1:0] HEX0,
  output logic [SEG_W-1:0] HEX1,
  output logic [SEG_W-1:0] HEX2,
  output logic [SEG_W-1:0] HEX3,
  output logic [SEG_W-1:0] HEX4,
  output logic [SEG_W-1:0] HEX5
);

  logic  clk;
  logic  rst_n;
  load_t load_c;
  logic  unused_c;

  assign clk      = KEY[0];
  assign rst_n    = KEY[3];
  assign unused_c = ^{CLOCK_50, KEY[2:1]};

  task4_fsm u_fsm (.clk(clk), .rst_n(rst_n), .load_c(load_c));

  task4_datapath dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_c (load_c),
    .hex0_c (HEX0),
    .hex1_c (HEX1),
    .hex2_c (HEX2),
    .hex3_c (HEX3),
    .hex4_c (HEX4),
    .hex5_c (HEX5),
    .ledr_c (LEDR)
  );

endmodule

// File: tb/tb_task4.sv
// Self-checking bench for task4: vector table plus scoreboard-checked deal sequences.
module tb_task4;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       clock_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [3:0] force_val = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  task4 dut (
    .CLOCK_50 (clock_50),
    .KEY      ({rst_n, 2'b00, clk}),
    .LEDR     (ledr),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5)
  );

  always #2 clock_50 = ~clock_50;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model of the dealer.
  logic [3:0] m_card [6];   // index = HEX digit: p1,p2,p3,d1,d2,d3
  int         m_st;
  logic [3:0] m_nc;

  typedef struct {
    logic [5:0][6:0] h;
    logic [9:0]      ledr;
    logic [3:0]      nc;
    bit              chk_nc;
    string           name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] seg(input logic [3:0] c);
    case (c)
      4'd1:  return 7'b0001000;
      4'd2:  return 7'b0100100;
      4'd3:  return 7'b0110000;
      4'd4:  return 7'b0011001;
      4'd5:  return 7'b0010010;
      4'd6:  return 7'b0000010;
      4'd7:  return 7'b1111000;
      4'd8:  return 7'b0000000;
      4'd9:  return 7'b0010000;
      4'd10: return 7'b1000000;
      4'd11: return 7'b1100001;
      4'd12: return 7'b0011000;
      4'd13: return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
  endfunction

  function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return 4'((val(a) + val(b) + val(c)) % 10);
  endfunction

  function automatic exp_t model_exp(input bit chk_nc, input string nm);
    exp_t e;
    for (int i = 0; i < 6; i++) e.h[i] = seg(m_card[i]);
    e.ledr   = {2'b00, score(m_card[3], m_card[4], m_card[5]), score(m_card[0], m_card[1], m_card[2])};
    e.nc     = m_nc;
    e.chk_nc = chk_nc;
    e.name   = nm;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    chk({e.name, " HEX0"}, 32'(hex0), 32'(e.h[0]));
    chk({e.name, " HEX1"}, 32'(hex1), 32'(e.h[1]));
    chk({e.name, " HEX2"}, 32'(hex2), 32'(e.h[2]));
    chk({e.name, " HEX3"}, 32'(hex3), 32'(e.h[3]));
    chk({e.name, " HEX4"}, 32'(hex4), 32'(e.h[4]));
    chk({e.name, " HEX5"}, 32'(hex5), 32'(e.h[5]));
    chk({e.name, " LEDR"}, 32'(ledr), 32'(e.ledr));
    if (e.chk_nc) chk({e.name, " new_card"}, 32'(dut.dp.DEL.new_card), 32'(e.nc));
  endtask

  // One game-clock edge: drive at negedge, predict, check just after posedge.
  task automatic step(input logic r, input bit frc, input logic [3:0] fv, input string nm);
    logic [3:0] cin;
    exp_t e;
    @(negedge clk);
    rst_n = r;
    if (frc) begin
      force_val = fv;
      force dut.dp.DEL.new_card = force_val;
    end else begin
      release dut.dp.DEL.new_card;
    end
    cin = frc ? fv : m_nc;
    if (!r) begin
      for (int i = 0; i < 6; i++) m_card[i] = 4'd0;
      m_st = 0;
      m_nc = 4'd1;
    end else begin
      case (m_st)
        0: m_card[0] = cin;
        1: m_card[3] = cin;
        2: m_card[1] = cin;
        3: m_card[4] = cin;
        default: ;
      endcase
      if (m_st < 4) m_st++;
      m_nc = (m_nc == 4'd13) ? 4'd1 : m_nc + 4'd1;
    end
    sb.push_back(model_exp(!frc, nm));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare_outputs(e);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [6:0] hex0, hex1, hex3, hex4;
    logic [7:0] led;
  } vec_t;

  vec_t vecs[6];

  initial begin
    exp_t e;
    logic [3:0] seq_a[4];
    logic [3:0] seq_b[4];

    // Unforced deal after reset: cards 1,2,3,4 dealt, then DONE holds.
    vecs[0] = '{1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 8'h00};
    vecs[1] = '{1'b1, 7'b0001000, 7'b1111111, 7'b1111111, 7'b1111111, 8'h01};
    vecs[2] = '{1'b1, 7'b0001000, 7'b1111111, 7'b0100100, 7'b1111111, 8'h21};
    vecs[3] = '{1'b1, 7'b0001000, 7'b0110000, 7'b0100100, 7'b1111111, 8'h24};
    vecs[4] = '{1'b1, 7'b0001000, 7'b0110000, 7'b0100100, 7'b0011001, 8'h64};
    vecs[5] = '{1'b1, 7'b0001000, 7'b0110000, 7'b0100100, 7'b0011001, 8'h64};

    m_st = 0;
    m_nc = 4'd1;
    for (int i = 0; i < 6; i++) m_card[i] = 4'd0;

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].rst_n, 1'b0, 4'd0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl HEX0", i), 32'(hex0), 32'(vecs[i].hex0));
      chk($sformatf("vec%0d tbl HEX1", i), 32'(hex1), 32'(vecs[i].hex1));
      chk($sformatf("vec%0d tbl HEX3", i), 32'(hex3), 32'(vecs[i].hex3));
      chk($sformatf("vec%0d tbl HEX4", i), 32'(hex4), 32'(vecs[i].hex4));
      chk($sformatf("vec%0d tbl LEDR", i), 32'(ledr), {24'd0, vecs[i].led});
    end

    // Card source keeps running in DONE and wraps king -> ace.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 4'd0, $sformatf("wrap%0d", i));

    // Forced deal 3, A, Q, 9, then a fifth edge in DONE.
    seq_a = '{4'd3, 4'd1, 4'd12, 4'd9};
    step(1'b0, 1'b0, 4'd0, "rstA");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, seq_a[i], $sformatf("dealA%0d", i));
    step(1'b1, 1'b1, 4'd5, "doneA");

    // Reset held without a clock edge must not disturb anything.
    clk_run = 1'b0;
    rst_n   = 1'b0;
    #40;
    e = model_exp(1'b0, "noedge");
    compare_outputs(e);
    rst_n   = 1'b1;
    clk_run = 1'b1;

    // Forced deal K, 4, 7, J.
    seq_b = '{4'd13, 4'd4, 4'd7, 4'd11};
    step(1'b0, 1'b0, 4'd0, "rstB");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, seq_b[i], $sformatf("dealB%0d", i));

    // Reset while in DEAL_P2 clears cards; next edge deals pcard1 again.
    step(1'b0, 1'b0, 4'd0, "rstC");
    step(1'b1, 1'b1, 4'd5, "dealC0");
    step(1'b1, 1'b1, 4'd6, "dealC1");
    step(1'b0, 1'b1, 4'd8, "rstmid");
    step(1'b1, 1'b1, 4'd2, "dealC2");

    // Reset from DONE, then all tens: show 1000000 and score zero.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd10, $sformatf("fill%0d", i));
    step(1'b0, 1'b0, 4'd0, "rstD");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd10, $sformatf("ten%0d", i));
    step(1'b1, 1'b1, 4'd14, "doneD");

    @(negedge clk);
    release dut.dp.DEL.new_card;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
